// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared types and default constants for the FIFO write arbiter
//
// Purpose: arbiter FSM state encoding and default parameter values used by
//          fifo_wr_arbiter and rr_picker.
// Ports:   none (package).
package shared_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    RESP       = 2'd2,
    WAIT_SPACE = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_FIFO_WIDTH   = 16;
  localparam int DEF_RETRY_MAX    = 3;
  localparam int DEF_RESP_TIMEOUT = 2;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - combinational round-robin request picker
//
// Purpose: finds the first set request bit searching upward from rr_ptr,
//          wrapping past N_REQ-1 back to 0.
// Ports:
//   req     in  N_REQ          request vector
//   rr_ptr  in  $clog2(N_REQ)  highest-priority index
//   valid   out 1              at least one request set
//   idx     out $clog2(N_REQ)  chosen requester
module rr_picker
  import shared_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit to rr_ptr
  // is the one left standing; the extra bit keeps the wrap exact for
  // non-power-of-two N_REQ.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
//
// Purpose: grants one of N_REQ producers, latches its word, issues a single
//          wr_en, then acks, retries (after waiting for space) or errors the
//          requester depending on the FIFO wr_ack/overflow response.
// Optional: define FIFO_ARB_STATS_EN to add stat_acc/stat_ovf counters.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req            per-requester level request
//   req_data       packed data, slice i for requester i
//   req_ack        one-cycle pulse, word accepted
//   req_err        one-cycle pulse, retries exhausted
//   fifo_wr_en     FIFO write enable
//   fifo_data_in   FIFO write data
//   fifo_full      FIFO full flag
//   fifo_wr_ack    FIFO write acknowledge
//   fifo_overflow  FIFO overflow flag
//   busy           high while not IDLE
//   grant_id       current or last granted requester
//   stat_acc       (optional) per-requester accepted-word counters, 16 bit each
//   stat_ovf       (optional) total overflow/timeout retries
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int FIFO_WIDTH   = DEF_FIFO_WIDTH,
  parameter int RETRY_MAX    = DEF_RETRY_MAX,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ack,
  output logic [N_REQ-1:0]            req_err,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         stat_acc,
  output logic [15:0]                 stat_ovf
`endif
);

  localparam int IW   = $clog2(N_REQ);
  localparam int RC_W = $clog2(RETRY_MAX + 1);
  localparam int TO_W = $clog2(RESP_TIMEOUT + 1);

  arb_state_e      state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [RC_W-1:0] retry_cnt, retry_n;
  logic [TO_W-1:0] to_cnt, to_n;

  logic [IW-1:0]         grant_n;
  logic [FIFO_WIDTH-1:0] data_n;
  logic                  wr_en_n;
  logic [N_REQ-1:0]      ack_n, err_n;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [FIFO_WIDTH-1:0] data_sel;
  logic [IW:0]           gid_inc;
  logic [IW-1:0]         ptr_after;
  logic                  resp_fail;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        data_sel = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Priority after a completed word starts just past the requester served.
  assign gid_inc   = {1'b0, grant_id} + (IW+1)'(1);
  assign ptr_after = (gid_inc >= (IW+1)'(N_REQ)) ? '0 : gid_inc[IW-1:0];

  // A silent FIFO for RESP_TIMEOUT cycles is handled exactly like overflow.
  assign resp_fail = fifo_overflow || (to_cnt == TO_W'(RESP_TIMEOUT - 1));

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    retry_n  = retry_cnt;
    to_n     = to_cnt;
    grant_n  = grant_id;
    data_n   = fifo_data_in;
    wr_en_n  = 1'b0;
    ack_n    = '0;
    err_n    = '0;
    case (state)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          grant_n = pick_idx;
          data_n  = data_sel;
          retry_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wr_en_n = 1'b1;
        to_n    = '0;
        state_n = RESP;
      end
      RESP: begin
        if (fifo_wr_ack) begin
          ack_n[grant_id] = 1'b1;
          rr_ptr_n        = ptr_after;
          state_n         = IDLE;
        end else if (resp_fail) begin
          retry_n = retry_cnt + RC_W'(1);
          if (retry_n == RC_W'(RETRY_MAX)) begin
            err_n[grant_id] = 1'b1;
            rr_ptr_n        = ptr_after;
            state_n         = IDLE;
          end else begin
            state_n = WAIT_SPACE;
          end
        end else begin
          to_n = to_cnt + TO_W'(1);
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full) begin
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      retry_cnt    <= '0;
      to_cnt       <= '0;
      grant_id     <= '0;
      fifo_data_in <= '0;
      fifo_wr_en   <= 1'b0;
      req_ack      <= '0;
      req_err      <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      retry_cnt    <= retry_n;
      to_cnt       <= to_n;
      grant_id     <= grant_n;
      fifo_data_in <= data_n;
      fifo_wr_en   <= wr_en_n;
      req_ack      <= ack_n;
      req_err      <= err_n;
      busy         <= (state_n != IDLE);
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] acc_cnt [N_REQ];
  logic [15:0] ovf_cnt;
  logic        ovf_evt;

  assign ovf_evt = (state == RESP) && !fifo_wr_ack && resp_fail;

  // Accepted words are counted off the registered ack pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        acc_cnt[i] <= '0;
      end
      ovf_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ack[i] && acc_cnt[i] != 16'hFFFF) begin
          acc_cnt[i] <= acc_cnt[i] + 16'd1;
        end
      end
      if (ovf_evt && ovf_cnt != 16'hFFFF) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    stat_acc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_acc[i*16 +: 16] = acc_cnt[i];
    end
  end

  assign stat_ovf = ovf_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_err;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic           busy;
  logic [1:0]     grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_acc;
  logic [15:0]     stat_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit ack_mode = 1'b0;
  bit ovf_mode = 1'b0;

  int n, n_ack, pulses, bad, acks, last_issue, gap_bad;
  bit err_seen;
  int acc [N];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(N), .FIFO_WIDTH(W), .RETRY_MAX(3), .RESP_TIMEOUT(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .req_err       (req_err),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow),
    .busy          (busy),
    .grant_id      (grant_id)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_acc      (stat_acc),
    .stat_ovf      (stat_ovf)
`endif
  );

  // FIFO write-side model: answers a write one cycle after it sees wr_en.
  initial begin : fifo_model
    bit seen;
    fifo_wr_ack   = 1'b0;
    fifo_overflow = 1'b0;
    forever begin
      @(negedge clk);
      seen = fifo_wr_en;
      @(posedge clk);
      #1;
      fifo_wr_ack   = seen & ack_mode;
      fifo_overflow = seen & ovf_mode;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    tick(); tick();
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_data", fifo_data_in, 0);
    check("rst_ack", req_ack, 0);
    check("rst_err", req_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;

    // Single write from requester 1.
    ack_mode = 1'b1;
    req_data = {16'h4444, 16'h3333, 16'hA5A5, 16'h1111};
    req = 4'b0010;
    tick();
    check("sw_grant", grant_id, 1);
    check("sw_busy", busy, 1);
    check("sw_wr_en_grant", fifo_wr_en, 0);
    req_data[31:16] = 16'h0000;
    tick();
    check("sw_wr_en", fifo_wr_en, 1);
    check("sw_data", fifo_data_in, 16'hA5A5);
    tick();
    check("sw_wr_en_drop", fifo_wr_en, 0);
    check("sw_ack_early", req_ack, 0);
    tick();
    check("sw_ack", req_ack, 4'b0010);
    check("sw_no_err", req_err, 0);
    req = '0;
    tick();
    check("sw_ack_pulse", req_ack, 0);
    check("sw_idle", busy, 0);

    // Round-robin with all requesters asserting, FIFO always accepting.
    rst = 1'b1; tick(); rst = 1'b0;
    req_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req = 4'b1111;
    for (int i = 0; i < N; i++) acc[i] = 0;
    n_ack = 0;
    for (int w = 0; w < 16; w++) begin
      n = 0;
      while (!fifo_wr_en && n < 10) begin tick(); n++; end
      check("rr_issue", fifo_wr_en, 1);
      check("rr_grant", grant_id, w % 4);
      check("rr_data", fifo_data_in, 16'hD000 + w % 4);
      if (w > 0) check("rr_period", n_ack + n, 4);
      n_ack = 0;
      while (req_ack == 0 && n_ack < 10) begin tick(); n_ack++; end
      check("rr_ack", req_ack, 1 << (w % 4));
      acc[w % 4]++;
      if (w == 3) for (int i = 0; i < N; i++) check("rr_first4", acc[i], 1);
      if (w == 15) req = '0;
    end
    for (int i = 0; i < N; i++) check("rr_acc16", acc[i], 4);
    tick();

    // Full stall: no grant while full, issue within 2 cycles of release.
    fifo_full = 1'b1;
    req = 4'b0001;
    req_data[15:0] = 16'hC0DE;
    bad = 0;
    repeat (10) begin tick(); if (fifo_wr_en || busy) bad++; end
    check("fs_stall", bad, 0);
    fifo_full = 1'b0;
    tick();
    check("fs_grant_busy", busy, 1);
    tick();
    check("fs_wr_en", fifo_wr_en, 1);
    check("fs_data", fifo_data_in, 16'hC0DE);
    n = 0;
    while (req_ack == 0 && n < 10) begin tick(); n++; end
    check("fs_ack", req_ack, 4'b0001);
    req = '0;
    tick();

    // Retry exhaustion: every attempt overflows.
    ack_mode = 1'b0; ovf_mode = 1'b1;
    req_data[15:0] = 16'hBEEF;
    req = 4'b0001;
    pulses = 0; bad = 0; acks = 0; err_seen = 1'b0; n = 0;
    while (!err_seen && n < 60) begin
      tick(); n++;
      if (fifo_wr_en) begin
        pulses++;
        if (fifo_data_in !== 16'hBEEF) bad++;
      end
      if (req_ack != 0) acks++;
      if (req_err != 0) begin
        err_seen = 1'b1;
        check("rx_err", req_err, 4'b0001);
      end
    end
    req = '0;
    check("rx_err_seen", err_seen, 1);
    check("rx_pulses", pulses, 3);
    check("rx_data", bad, 0);
    check("rx_no_ack", acks, 0);
    tick();
    check("rx_err_pulse", req_err, 0);

    // Timeout: FIFO silent; requester 1 errors, then requester 0 is served.
    ovf_mode = 1'b0;
    req_data = {16'h4444, 16'h3333, 16'h7777, 16'h6666};
    req = 4'b0011;
    pulses = 0; gap_bad = 0; err_seen = 1'b0; n = 0; last_issue = 0;
    while (!err_seen && n < 60) begin
      tick(); n++;
      if (fifo_wr_en) begin
        if (grant_id !== 2'd1) gap_bad++;
        if (pulses > 0 && n - last_issue != 4) gap_bad++;
        pulses++;
        last_issue = n;
      end
      if (req_err != 0) begin
        err_seen = 1'b1;
        check("to_err", req_err, 4'b0010);
        check("to_err_delay", n - last_issue, 2);
      end
    end
    req = 4'b0001;
    ack_mode = 1'b1;
    check("to_err_seen", err_seen, 1);
    check("to_pulses", pulses, 3);
    check("to_spacing", gap_bad, 0);
    n = 0;
    while (!fifo_wr_en && n < 10) begin tick(); n++; end
    check("to_next_grant", grant_id, 0);
    check("to_next_data", fifo_data_in, 16'h6666);
    n = 0;
    while (req_ack == 0 && n < 10) begin tick(); n++; end
    check("to_next_ack", req_ack, 4'b0001);
    req = '0;
    tick();

    // Reset during RESP: rr_ptr is 1 here, so req 0101 picks 2 before reset
    // and 0 after it.
    ack_mode = 1'b0;
    req = 4'b0101;
    tick();
    check("ro_grant_pre", grant_id, 2);
    tick();
    check("ro_wr_en_pre", fifo_wr_en, 1);
    rst = 1'b1;
    #1;
    check("ro_outputs_zero", {fifo_wr_en, busy, grant_id, fifo_data_in, req_ack, req_err}, 0);
    bad = 0;
    repeat (3) begin tick(); if (req_ack != 0 || req_err != 0 || busy || fifo_wr_en) bad++; end
    check("ro_held", bad, 0);
    rst = 1'b0;
    ack_mode = 1'b1;
    tick();
    check("ro_regrant", grant_id, 0);
    check("ro_busy", busy, 1);
    n = 0;
    while (req_ack == 0 && n < 10) begin tick(); n++; end
    check("ro_ack", req_ack, 4'b0001);
    req = '0;
    tick(); tick();

`ifdef FIFO_ARB_STATS_EN
    check("st_acc0", stat_acc[15:0], 1);
    check("st_acc2", stat_acc[47:32], 0);
    check("st_ovf", stat_ovf, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
